// File: rtl/wb_lockstep_checker.sv
// rtl/wb_lockstep_checker.sv - N-channel register-writeback lockstep checker
// Per-channel FIFOs pop in lockstep; every channel is compared against channel 0.
module wb_lockstep_checker #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic                                   clear,
  input  logic [NUM_CH-1:0]                      wb_valid,
  input  logic [NUM_CH*ADDR_W-1:0]               wb_dest,
  input  logic [NUM_CH*DATA_W-1:0]               wb_value,
  output logic [31:0]                            compare_count,
  output logic                                   mismatch,
  output logic [NUM_CH-1:0]                      mismatch_ch,
  output logic [ADDR_W-1:0]                      mismatch_dest,
  output logic [31:0]                            mismatch_index,
  output logic [NUM_CH-1:0]                      overflow,
  output logic                                   timeout,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]    fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int REC_W = ADDR_W + DATA_W;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  logic [REC_W-1:0]  mem    [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr [NUM_CH];
  logic [LVL_W-1:0]  level  [NUM_CH];
  logic [REC_W-1:0]  head   [NUM_CH];

  logic [NUM_CH-1:0] not_empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] diff;
  logic              all_ne;
  logic              any_ne;
  logic              pop;
  logic              skewed;
  logic [TO_W-1:0]   to_cnt;

  always_comb begin
    not_empty = '0;
    full      = '0;
    push      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      not_empty[i] = (level[i] != '0);
      full[i]      = (level[i] == LVL_W'(DEPTH));
      push[i]      = en & wb_valid[i];
      head[i]      = mem[i][rd_ptr[i]];
    end
  end

  assign all_ne = &not_empty;
  assign any_ne = |not_empty;
  assign pop    = en & all_ne;
  assign skewed = any_ne & ~all_ne;

  // A full FIFO can still accept when the lockstep pop frees a slot this cycle.
  always_comb begin
    accept = push & (~full | {NUM_CH{pop}});
  end

  always_comb begin
    diff = '0;
    for (int i = 1; i < NUM_CH; i++) begin
      diff[i] = (head[i] != head[0]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst && !clear && accept[i]) begin
        mem[i][wr_ptr[i]] <= {wb_dest[i*ADDR_W +: ADDR_W], wb_value[i*DATA_W +: DATA_W]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        level[i]  <= '0;
      end
      overflow <= '0;
    end else if (en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        end
        if (accept[i] && !pop) begin
          level[i] <= level[i] + LVL_W'(1);
        end else if (!accept[i] && pop) begin
          level[i] <= level[i] - LVL_W'(1);
        end
        if (push[i] && full[i] && !pop) begin
          overflow[i] <= 1'b1;
        end
      end
    end
  end

  // Only the first mismatch is captured; compares keep counting afterwards.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      compare_count  <= '0;
      mismatch       <= 1'b0;
      mismatch_ch    <= '0;
      mismatch_dest  <= '0;
      mismatch_index <= '0;
    end else if (en && pop) begin
      if (compare_count != 32'hFFFF_FFFF) begin
        compare_count <= compare_count + 32'd1;
      end
      if (|diff && !mismatch) begin
        mismatch       <= 1'b1;
        mismatch_ch    <= diff;
        mismatch_dest  <= head[0][REC_W-1 -: ADDR_W];
        mismatch_index <= compare_count;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else if (en) begin
      if (skewed) begin
        if (to_cnt != TO_W'(TIMEOUT)) begin
          to_cnt <= to_cnt + TO_W'(1);
          if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
          end
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_level
    assign fifo_level[g*LVL_W +: LVL_W] = level[g];
  end

endmodule

// File: tb/tb_wb_lockstep_checker.sv
// tb/tb_wb_lockstep_checker.sv - table, directed and randomized checks of wb_lockstep_checker
// Random phase compares against a queue-based model of the lockstep rules.
module tb_wb_lockstep_checker;
  localparam int NC = 2;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DP = 8;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst, en, clr;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_dest;
  logic [63:0] wb_value;
  logic [31:0] compare_count, mismatch_index;
  logic        mismatch, timeout;
  logic [1:0]  mismatch_ch, overflow;
  logic [3:0]  mismatch_dest;
  logic [7:0]  fifo_level;

  wb_lockstep_checker #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clr),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_value(wb_value),
    .compare_count(compare_count), .mismatch(mismatch), .mismatch_ch(mismatch_ch),
    .mismatch_dest(mismatch_dest), .mismatch_index(mismatch_index),
    .overflow(overflow), .timeout(timeout), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        en, clr;
    logic [1:0]  v;
    logic [3:0]  d0;
    logic [31:0] x0;
    logic [3:0]  d1;
    logic [31:0] x1;
    int          cc;
    logic        mm;
    logic [1:0]  mch;
    logic [3:0]  mdest;
    int          midx;
    int          l0, l1;
  } vec_t;

  vec_t tbl[11];

  // Reference model: one queue per channel, status kept as plain variables.
  logic [35:0] mq0[$], mq1[$];
  logic [31:0] m_cc, m_idx;
  logic        m_mm, m_to;
  logic [1:0]  m_ch, m_ovf;
  logic [3:0]  m_dest;
  int          m_tc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic c, input logic [1:0] v,
                       input logic [3:0] d0, input logic [31:0] x0,
                       input logic [3:0] d1, input logic [31:0] x1);
    en = e; clr = c; wb_valid = v;
    wb_dest = {d1, d0};
    wb_value = {x1, x0};
  endtask

  task automatic model_step();
    logic [35:0] r0, r1, h0, h1;
    int n0, n1;
    bit p;
    r0 = {wb_dest[3:0], wb_value[31:0]};
    r1 = {wb_dest[7:4], wb_value[63:32]};
    if (rst || clr) begin
      mq0.delete(); mq1.delete();
      m_cc = 0; m_idx = 0; m_mm = 0; m_to = 0; m_ch = 0; m_ovf = 0; m_dest = 0; m_tc = 0;
    end else if (en) begin
      n0 = mq0.size(); n1 = mq1.size();
      p = (n0 > 0) && (n1 > 0);
      if (p) begin
        h0 = mq0.pop_front(); h1 = mq1.pop_front();
        if (h0 != h1 && !m_mm) begin
          m_mm = 1; m_ch = 2'b10; m_dest = h0[35:32]; m_idx = m_cc;
        end
        if (m_cc != 32'hFFFF_FFFF) m_cc = m_cc + 1;
      end
      if (wb_valid[0]) begin
        if (n0 < DP || p) mq0.push_back(r0); else m_ovf[0] = 1;
      end
      if (wb_valid[1]) begin
        if (n1 < DP || p) mq1.push_back(r1); else m_ovf[1] = 1;
      end
      if ((n0 > 0) != (n1 > 0)) begin
        if (m_tc < TO) m_tc++;
        if (m_tc == TO) m_to = 1;
      end else begin
        m_tc = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cc"}, compare_count, 0);
    chk({tag, "_mm"}, mismatch, 0);
    chk({tag, "_mch"}, mismatch_ch, 0);
    chk({tag, "_mdest"}, mismatch_dest, 0);
    chk({tag, "_midx"}, mismatch_index, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_to"}, timeout, 0);
    chk({tag, "_lvl"}, fifo_level, 0);
  endtask

  task automatic do_clear();
    drive(1, 1, 2'b00, 0, 0, 0, 0);
    tick();
    drive(1, 0, 2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    int pk, rise;
    logic [31:0] s0, s1;
    int p0, p1;
    int probs[5];

    rst = 1;
    drive(0, 0, 2'b11, 4'hF, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF);
    tick(); tick();
    chk_zero("reset");
    rst = 0;

    // en, clr, valid, d0, x0, d1, x1 -> cc, mm, mch, mdest, midx, l0, l1
    tbl[0]  = '{1, 0, 2'b11, 3, 32'h10,        3, 32'h10,        0, 0, 2'b00, 0, 0, 1, 1};
    tbl[1]  = '{1, 0, 2'b11, 5, 32'hDEAD_BEEF, 5, 32'hDEAD_BEEF, 1, 0, 2'b00, 0, 0, 1, 1};
    tbl[2]  = '{1, 0, 2'b00, 0, 32'h0,         0, 32'h0,         2, 0, 2'b00, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 2'b00, 0, 32'h0,         0, 32'h0,         2, 0, 2'b00, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 2'b11, 7, 32'h12,        7, 32'h11,        2, 0, 2'b00, 0, 0, 1, 1};
    tbl[5]  = '{1, 0, 2'b00, 0, 32'h0,         0, 32'h0,         3, 1, 2'b10, 7, 2, 0, 0};
    tbl[6]  = '{1, 0, 2'b11, 1, 32'h5,         2, 32'h5,         3, 1, 2'b10, 7, 2, 1, 1};
    tbl[7]  = '{0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         3, 1, 2'b10, 7, 2, 1, 1};
    tbl[8]  = '{1, 0, 2'b00, 0, 32'h0,         0, 32'h0,         4, 1, 2'b10, 7, 2, 0, 0};
    tbl[9]  = '{0, 0, 2'b11, 1, 32'h1,         1, 32'h1,         4, 1, 2'b10, 7, 2, 0, 0};
    tbl[10] = '{1, 1, 2'b11, 1, 32'h1,         1, 32'h1,         0, 0, 2'b00, 0, 0, 0, 0};

    for (int k = 0; k < 11; k++) begin
      drive(tbl[k].en, tbl[k].clr, tbl[k].v, tbl[k].d0, tbl[k].x0, tbl[k].d1, tbl[k].x1);
      tick();
      chk($sformatf("tbl%0d_cc", k), compare_count, tbl[k].cc);
      chk($sformatf("tbl%0d_mm", k), mismatch, tbl[k].mm);
      chk($sformatf("tbl%0d_mch", k), mismatch_ch, tbl[k].mch);
      chk($sformatf("tbl%0d_mdest", k), mismatch_dest, tbl[k].mdest);
      chk($sformatf("tbl%0d_midx", k), mismatch_index, tbl[k].midx);
      chk($sformatf("tbl%0d_l0", k), fifo_level[3:0], tbl[k].l0);
      chk($sformatf("tbl%0d_l1", k), fifo_level[7:4], tbl[k].l1);
      chk($sformatf("tbl%0d_ovf", k), overflow, 0);
      chk($sformatf("tbl%0d_to", k), timeout, 0);
    end

    // Skewed arrival: channel 1 trails channel 0 by 5 cycles.
    do_clear();
    pk = 0;
    for (int c = 0; c < 20; c++) begin
      drive(1, 0, {(c >= 5 && c < 9), (c < 4)},
            4'(c), 32'(100 + c), 4'(c - 5), 32'(95 + c));
      tick();
      if (int'(fifo_level[3:0]) > pk) pk = fifo_level[3:0];
    end
    chk("skew_peak", pk, 4);
    chk("skew_cc", compare_count, 4);
    chk("skew_mm", mismatch, 0);
    chk("skew_to", timeout, 0);

    // Timeout: a lone record in channel 0.
    do_clear();
    drive(1, 0, 2'b01, 1, 32'h1, 0, 0);
    tick();
    chk("to_lvl", fifo_level[3:0], 1);
    drive(1, 0, 2'b00, 0, 0, 0, 0);
    rise = -1;
    for (int n = 1; n <= 24; n++) begin
      tick();
      if (rise < 0 && timeout === 1'b1) rise = n;
    end
    chk("to_rise", rise, 16);
    chk("to_hold_lvl", fifo_level[3:0], 1);

    // Overflow at DEPTH, then push that coincides with the lockstep pop.
    do_clear();
    for (int k = 0; k < 9; k++) begin
      drive(1, 0, 2'b01, 4'(k), 32'(k * 3), 0, 0);
      tick();
    end
    chk("ovf_flag", overflow, 2'b01);
    chk("ovf_lvl0", fifo_level[3:0], 8);
    drive(1, 0, 2'b10, 0, 0, 4'd0, 32'd0);
    tick();
    chk("ovf_a_lvl1", fifo_level[7:4], 1);
    drive(1, 0, 2'b11, 4'd9, 32'd27, 4'd1, 32'd3);
    tick();
    chk("ovf_b_lvl0", fifo_level[3:0], 8);
    chk("ovf_b_lvl1", fifo_level[7:4], 1);
    chk("ovf_b_flag", overflow, 2'b01);
    chk("ovf_b_cc", compare_count, 1);
    chk("ovf_b_mm", mismatch, 0);

    // Reset with records buffered and a mismatch latched.
    do_clear();
    drive(1, 0, 2'b11, 1, 32'h1, 1, 32'h2);
    tick();
    drive(1, 0, 2'b00, 0, 0, 0, 0);
    tick();
    chk("rmid_mm", mismatch, 1);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 2'b01, 4'(k), 32'(k), 0, 0);
      tick();
    end
    chk("rmid_lvl0", fifo_level[3:0], 3);
    rst = 1;
    drive(1, 0, 2'b11, 6, 32'h6, 6, 32'h6);
    tick();
    rst = 0;
    chk_zero("rmid");
    drive(1, 0, 2'b11, 2, 32'h55, 2, 32'h55);
    tick();
    drive(1, 0, 2'b00, 0, 0, 0, 0);
    tick();
    chk("rmid_cc", compare_count, 1);
    chk("rmid_mm2", mismatch, 0);
    chk("rmid_lvl", fifo_level, 0);

    // Randomized phase against the queue model.
    probs = '{0, 25, 60, 90, 100};
    s0 = 0; s1 = 0; p0 = 60; p1 = 60;
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] v;
      logic [31:0] x0, x1;
      if (c % 100 == 0) begin
        p0 = probs[$urandom_range(0, 4)];
        p1 = probs[$urandom_range(0, 4)];
      end
      rst = ($urandom_range(0, 999) < 4);
      v = {($urandom_range(0, 99) < p1), ($urandom_range(0, 99) < p0)};
      x0 = s0 * 32'h9E37 + 1;
      x1 = s1 * 32'h9E37 + 1;
      if ($urandom_range(0, 299) == 0) x1 = x1 ^ 32'h1;
      drive($urandom_range(0, 99) < 92, $urandom_range(0, 99) < 1, v, s0[3:0], x0, s1[3:0], x1);
      if (rst || clr) begin
        s0 = 0; s1 = 0;
      end else if (en) begin
        if (v[0]) s0++;
        if (v[1]) s1++;
      end
      tick();
      chk($sformatf("rnd%0d_cc", c), compare_count, m_cc);
      chk($sformatf("rnd%0d_mm", c), mismatch, m_mm);
      chk($sformatf("rnd%0d_mch", c), mismatch_ch, m_ch);
      chk($sformatf("rnd%0d_mdest", c), mismatch_dest, m_dest);
      chk($sformatf("rnd%0d_midx", c), mismatch_index, m_idx);
      chk($sformatf("rnd%0d_ovf", c), overflow, m_ovf);
      chk($sformatf("rnd%0d_to", c), timeout, m_to);
      chk($sformatf("rnd%0d_l0", c), fifo_level[3:0], mq0.size());
      chk($sformatf("rnd%0d_l1", c), fifo_level[7:4], mq1.size());
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
